// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
);
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// Results are registered and presented together with a one-cycle done pulse.
module seq_divider #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [DVD_W-1:0] dq;        // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [DVS_W-1:0] dvs;
    logic [DVS_W:0]   prem;      // partial remainder
    logic [CNT_W-1:0] cnt;
    logic             zflag;     // current division is a divide-by-zero
    logic             accept;
    logic             zero_div;
    logic [DVS_W+1:0] shifted;
    logic             qbit;
    logic [DVS_W:0]   prem_nxt;

    assign accept   = (state == IDLE) && bus.start;
    assign zero_div = (bus.divisor == '0);

    // Restoring step: a non-negative trial subtraction is the same as shifted >= divisor.
    always_comb begin
        shifted  = {prem, dq[DVD_W-1]};
        qbit     = (shifted >= (DVS_W+2)'(dvs));
        prem_nxt = qbit ? (DVS_W+1)'(shifted - (DVS_W+2)'(dvs)) : shifted[DVS_W:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: divide-by-zero skips CALC, CALC runs DVD_W steps.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = zero_div ? DONE : CALC;
            CALC: if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags lag the state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dq            <= '0;
            dvs           <= '0;
            prem          <= '0;
            cnt           <= '0;
            zflag         <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.dbz       <= 1'b0;
        end else begin
            bus.busy <= (state == CALC);
            bus.done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        dq    <= bus.dividend;
                        dvs   <= bus.divisor;
                        prem  <= '0;
                        zflag <= zero_div;
                        cnt   <= zero_div ? '0 : CNT_W'(DVD_W);
                        if (!zero_div) bus.dbz <= 1'b0;
                    end
                end
                CALC: begin
                    dq   <= (dq << 1) | DVD_W'(qbit);
                    prem <= prem_nxt;
                    cnt  <= cnt - CNT_W'(1);
                end
                DONE: begin
                    bus.quotient  <= zflag ? '1 : dq;
                    bus.remainder <= zflag ? '0 : prem[DVS_W-1:0];
                    bus.dbz       <= zflag;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: vector table, corner-case sequences, exhaustive sweep.
module tb_seq_divider;
    localparam int DVD_W = 8;
    localparam int DVS_W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_divider_if #(.DVD_W(DVD_W), .DVS_W(DVS_W)) bus();

    seq_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result monitor: every done pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (bus.done === 1'b1) begin
            check("busy_with_done", 32'(bus.busy), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending result at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(bus.quotient), 32'(e.q));
                check("remainder", 32'(bus.remainder), 32'(e.r));
                check("dbz", 32'(bus.dbz), 32'(e.z));
                if (e.b != 4'd0)
                    check("identity", 32'((int'(bus.quotient) * int'(e.b) + int'(bus.remainder) == int'(e.a))
                                          && (bus.remainder < e.b)), 32'd1);
            end
        end
    end

    // One division with latency/busy profile and result hold checks.
    task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic ez);
        int   lat;
        vec_t v;
        lat = (b == 4'd0) ? 1 : DVD_W + 1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        v = '{a, b, eq, er, ez};
        sb.push_back(v);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            check("busy_timing", 32'(bus.busy), 32'((b != 4'd0) && (k <= DVD_W)));
            check("done_timing", 32'(bus.done), 32'(k == lat));
        end
        check("hold_quotient", 32'(bus.quotient), 32'(eq));
        check("hold_remainder", 32'(bus.remainder), 32'(er));
        check("hold_dbz", 32'(bus.dbz), 32'(ez));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;

        tbl[0]  = '{8'd100, 4'd7,  8'd14,  4'd2,  1'b0};
        tbl[1]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        tbl[2]  = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
        tbl[3]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        tbl[4]  = '{8'd42,  4'd0,  8'hFF,  4'd0,  1'b1};
        tbl[5]  = '{8'd42,  4'd6,  8'd7,   4'd0,  1'b0};
        tbl[6]  = '{8'd9,   4'd2,  8'd4,   4'd1,  1'b0};
        tbl[7]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
        tbl[8]  = '{8'd200, 4'd3,  8'd66,  4'd2,  1'b0};
        tbl[9]  = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0};
        tbl[10] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};
        tbl[11] = '{8'd0,   4'd0,  8'hFF,  4'd0,  1'b1};
        tbl[12] = '{8'd1,   4'd1,  8'd1,   4'd0,  1'b0};
        tbl[13] = '{8'd7,   4'd8,  8'd0,   4'd7,  1'b0};

        // Reset state
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz", 32'(bus.dbz), 32'd0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 14; i++)
            do_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);

        // Start while busy (CALC and DONE), operands disturbed mid-CALC
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd7;
        v = '{8'd100, 4'd7, 8'd14, 4'd2, 1'b0};
        sb.push_back(v);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            case (k)
                3, 9: begin bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd3; end
                4:    begin bus.start = 1'b0; bus.dividend = 8'hAA;  bus.divisor = 4'd1; end
                10:   bus.start = 1'b0;
                default: ;
            endcase
            @(posedge clk); #1;
            check("busy_ignore_start", 32'(bus.busy), 32'(k <= DVD_W));
            check("done_ignore_start", 32'(bus.done), 32'(k == DVD_W + 1));
        end

        // Reset four cycles into CALC
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_quotient", 32'(bus.quotient), 32'd0);
        check("midrst_remainder", 32'(bus.remainder), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_dbz", 32'(bus.dbz), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 32'(bus.done), 32'd0);
            check("no_busy_after_rst", 32'(bus.busy), 32'd0);
        end
        do_div(8'd9, 4'd2, 8'd4, 4'd1, 1'b0);

        // Reset wins over start on the same edge
        @(negedge clk);
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 4'd5;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("rst_prio_busy", 32'(bus.busy), 32'd0);
            check("rst_prio_done", 32'(bus.done), 32'd0);
        end

        // Exhaustive sweep of nonzero divisors
        for (int unsigned a = 0; a < 256; a++)
            for (int unsigned b = 1; b < 16; b++)
                do_div(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
